// File: rtl/serial_compare.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle.
// Define SIGNED_CMP_EN for two's-complement operands.
module serial_compare #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             equal,
  output logic             bigger
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             bigger_q, bigger_d;
  logic             done_q, done_d;
  logic [CHUNK-1:0] chunk_a, chunk_b;

  assign chunk_a = opa_q[int'(idx_q)*CHUNK +: CHUNK];
  assign chunk_b = opb_q[int'(idx_q)*CHUNK +: CHUNK];

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    idx_d    = idx_q;
    less_d   = less_q;
    equal_d  = equal_q;
    bigger_d = bigger_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = in1;
          opb_d   = in2;
          idx_d   = LAST;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef SIGNED_CMP_EN
        // differing sign bits settle the result before any scan
        if (idx_q == LAST &&
            opa_q[WIDTH-1] != opb_q[WIDTH-1]) begin
          less_d   = opa_q[WIDTH-1];
          bigger_d = ~opa_q[WIDTH-1];
          equal_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else
`endif
        if (chunk_a != chunk_b) begin
          less_d   = (chunk_a < chunk_b);
          bigger_d = (chunk_a > chunk_b);
          equal_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (idx_q == '0) begin
          less_d   = 1'b0;
          bigger_d = 1'b0;
          equal_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      idx_q    <= '0;
      less_q   <= 1'b0;
      equal_q  <= 1'b0;
      bigger_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      idx_q    <= idx_d;
      less_q   <= less_d;
      equal_q  <= equal_d;
      bigger_q <= bigger_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign less   = less_q;
  assign equal  = equal_q;
  assign bigger = bigger_q;

endmodule

// File: tb/tb_serial_compare.sv
// Scoreboard bench for serial_compare (WIDTH=16, CHUNK=4).
// Expected flags/latency queued at start, checked on done.
module tb_serial_compare;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  typedef struct {
    logic [2:0] flags;
    int         e0;
    int         m;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;
  logic        busy, done, less, equal, bigger;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   bcnt = 0;
  exp_t q[$];

  serial_compare #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in1(in1), .in2(in2), .busy(busy), .done(done),
    .less(less), .equal(equal), .bigger(bigger)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: pop on done, check flags, latency, busy length
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check({e.tag, "_flags"},
              int'({less, equal, bigger}), int'(e.flags));
        check({e.tag, "_lat"}, cyc - e.e0, e.m);
        check({e.tag, "_busy"}, bcnt, e.m);
        check({e.tag, "_busy_lo"}, int'(busy), 0);
      end
      bcnt = 0;
    end else if (busy) begin
      bcnt++;
    end else begin
      bcnt = 0;
    end
  end

  task automatic start_op(input logic [15:0] a,
                          input logic [15:0] b,
                          input logic [2:0] f,
                          input int m,
                          input string tag,
                          input bit push);
    exp_t e;
    in1 = a;
    in2 = b;
    start = 1'b1;
    if (push) begin
      e.flags = f;
      e.e0 = cyc + 1;
      e.m = m;
      e.tag = tag;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_drain"}, q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_flags", int'({less, equal, bigger}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(16'h1234, 16'h1234, EQ, 4, "eq", 1);
    drain("eq");
    @(negedge clk);

`ifdef SIGNED_CMP_EN
    start_op(16'h9000, 16'h1FFF, LT, 1, "msb", 1);
`else
    start_op(16'h9000, 16'h1FFF, GT, 1, "msb", 1);
`endif
    drain("msb");
    @(negedge clk);

    start_op(16'h8000, 16'h0001,
`ifdef SIGNED_CMP_EN
             LT,
`else
             GT,
`endif
             1, "sign", 1);
    drain("sign");
    @(negedge clk);

    start_op(16'hFFF0, 16'hFFF8, LT, 4, "neg", 1);
    drain("neg");
    @(negedge clk);

    // second start issued in the done cycle of the first
    start_op(16'h12A0, 16'h12B0, LT, 3, "b2b_a", 1);
    repeat (3) @(negedge clk);
    check("b2b_done_cyc", int'(done), 1);
    start_op(16'h0001, 16'h0000, GT, 4, "b2b_b", 1);
    drain("b2b");
    @(negedge clk);

    // start while busy must be ignored
    start_op(16'hAAAA, 16'hAAAA, EQ, 4, "ign", 1);
    start = 1'b1;
    in1 = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    in1 = 16'hAAAA;
    drain("ign");
    repeat (6) @(negedge clk);
    check("ign_idle", int'(busy), 0);

    // reset abandons an in-flight compare; prior result bigger
    start_op(16'h0001, 16'h0000, GT, 4, "pre", 1);
    drain("pre");
    @(negedge clk);
    start_op(16'h1234, 16'h1234, EQ, 4, "abort", 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_flags", int'({less, equal, bigger}), 0);
    repeat (6) @(negedge clk);
    check("abort_quiet", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
